// File: rtl/dec_pkg.sv
// Shared decode definitions for the dec_stage pipeline stage: opcodes, op_mode/func_op
// encodings and the packed decoded bundle carried from decoder to output register.
package dec_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] OPM_NONE  = 3'd0;
  localparam logic [2:0] OPM_LOGIC = 3'd1;
  localparam logic [2:0] OPM_SHIFT = 3'd2;
  localparam logic [2:0] OPM_CMP   = 3'd3;
  localparam logic [2:0] OPM_ADD   = 3'd4;
  localparam logic [2:0] OPM_MUL   = 3'd5;
  localparam logic [2:0] OPM_DIV   = 3'd6;
  localparam logic [2:0] OPM_REM   = 3'd7;

  localparam logic [2:0] FOP_AND      = 3'b000;
  localparam logic [2:0] FOP_OR       = 3'b001;
  localparam logic [2:0] FOP_XOR      = 3'b010;
  localparam logic [2:0] FOP_SLL      = 3'b000;
  localparam logic [2:0] FOP_SRL      = 3'b010;
  localparam logic [2:0] FOP_SRA      = 3'b011;
  localparam logic [2:0] FOP_LT       = 3'b000;
  localparam logic [2:0] FOP_LTU      = 3'b001;
  localparam logic [2:0] FOP_GEU      = 3'b010;
  localparam logic [2:0] FOP_GE       = 3'b011;
  localparam logic [2:0] FOP_NE       = 3'b100;
  localparam logic [2:0] FOP_EQ       = 3'b101;
  localparam logic [2:0] FOP_ADD      = 3'b000;
  localparam logic [2:0] FOP_SUB      = 3'b001;
  localparam logic [2:0] FOP_MUL      = 3'b000;
  localparam logic [2:0] FOP_MULH     = 3'b001;
  localparam logic [2:0] FOP_MULHSU   = 3'b010;
  localparam logic [2:0] FOP_MULHU    = 3'b011;
  localparam logic [2:0] FOP_SIGNED   = 3'b000;
  localparam logic [2:0] FOP_UNSIGNED = 3'b001;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [2:0]  op_mode;
    logic [2:0]  func_op;
    logic        alusrc;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        pc_rel;
    logic        illegal;
  } dec_bundle_t;

  // Shared OP / OP-IMM funct3 mapping; alt selects SUB/SRA (funct7[5]).
  function automatic logic [5:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [5:0] sel;
    case (f3)
      3'b000:  sel = alt ? {OPM_ADD, FOP_SUB} : {OPM_ADD, FOP_ADD};
      3'b001:  sel = {OPM_SHIFT, FOP_SLL};
      3'b010:  sel = {OPM_CMP, FOP_LT};
      3'b011:  sel = {OPM_CMP, FOP_LTU};
      3'b100:  sel = {OPM_LOGIC, FOP_XOR};
      3'b101:  sel = alt ? {OPM_SHIFT, FOP_SRA} : {OPM_SHIFT, FOP_SRL};
      3'b110:  sel = {OPM_LOGIC, FOP_OR};
      default: sel = {OPM_LOGIC, FOP_AND};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dec_core.sv
// Purely combinational RV32I decoder: instruction word to decoded bundle.
// RV32M decode is included only when DEC_RV32M_EN is defined; otherwise those encodings are illegal.
module dec_core
  import dec_pkg::*;
(
  input  logic [31:0] i_inst,
  output dec_bundle_t o_bundle
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  dec_bundle_t b;
  logic        bad;

  assign opc   = i_inst[6:0];
  assign f7    = i_inst[31:25];
  assign f3    = i_inst[14:12];
  assign rd    = i_inst[11:7];
  assign rs1   = i_inst[19:15];
  assign rs2   = i_inst[24:20];
  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  always_comb begin
    b   = '0;
    bad = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        b.rd        = rd;
        b.imm       = imm_u;
        b.op_mode   = OPM_ADD;
        b.func_op   = FOP_ADD;
        b.alusrc    = 1'b1;
        b.reg_write = 1'b1;
        b.pc_rel    = (opc == OPC_AUIPC);
      end
      OPC_JAL, OPC_JALR: begin
        bad         = (opc == OPC_JALR) && (f3 != 3'b000);
        b.rd        = rd;
        b.rs1       = (opc == OPC_JALR) ? rs1 : 5'd0;
        b.imm       = (opc == OPC_JALR) ? imm_i : imm_j;
        b.op_mode   = OPM_ADD;
        b.func_op   = FOP_ADD;
        b.alusrc    = 1'b1;
        b.reg_write = 1'b1;
        b.jump      = 1'b1;
        b.jalr      = (opc == OPC_JALR);
        b.pc_rel    = (opc == OPC_JAL);
      end
      OPC_BRANCH: begin
        bad       = (f3 == 3'b010) || (f3 == 3'b011);
        b.rs1     = rs1;
        b.rs2     = rs2;
        b.imm     = imm_b;
        b.op_mode = OPM_CMP;
        b.branch  = 1'b1;
        case (f3)
          3'b000:  b.func_op = FOP_EQ;
          3'b001:  b.func_op = FOP_NE;
          3'b100:  b.func_op = FOP_LT;
          3'b101:  b.func_op = FOP_GE;
          3'b110:  b.func_op = FOP_LTU;
          default: b.func_op = FOP_GEU;
        endcase
      end
      OPC_LOAD: begin
        bad          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        b.rd         = rd;
        b.rs1        = rs1;
        b.imm        = imm_i;
        b.op_mode    = OPM_ADD;
        b.func_op    = FOP_ADD;
        b.alusrc     = 1'b1;
        b.mem_to_reg = 1'b1;
        b.reg_write  = 1'b1;
        b.mem_read   = 1'b1;
      end
      OPC_STORE: begin
        bad         = f3[2] || (f3 == 3'b011);
        b.rs1       = rs1;
        b.rs2       = rs2;
        b.imm       = imm_s;
        b.op_mode   = OPM_ADD;
        b.func_op   = FOP_ADD;
        b.alusrc    = 1'b1;
        b.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        bad = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
              ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
        b.rd        = rd;
        b.rs1       = rs1;
        b.imm       = imm_i;
        b.alusrc    = 1'b1;
        b.reg_write = 1'b1;
        {b.op_mode, b.func_op} = alu_sel(f3, (f3 == 3'b101) && f7[5]);
      end
      OPC_OP: begin
        b.rd        = rd;
        b.rs1       = rs1;
        b.rs2       = rs2;
        b.reg_write = 1'b1;
        if (f7 == 7'b0000001) begin
`ifdef DEC_RV32M_EN
          case (f3)
            3'b000:  {b.op_mode, b.func_op} = {OPM_MUL, FOP_MUL};
            3'b001:  {b.op_mode, b.func_op} = {OPM_MUL, FOP_MULH};
            3'b010:  {b.op_mode, b.func_op} = {OPM_MUL, FOP_MULHSU};
            3'b011:  {b.op_mode, b.func_op} = {OPM_MUL, FOP_MULHU};
            3'b100:  {b.op_mode, b.func_op} = {OPM_DIV, FOP_SIGNED};
            3'b101:  {b.op_mode, b.func_op} = {OPM_DIV, FOP_UNSIGNED};
            3'b110:  {b.op_mode, b.func_op} = {OPM_REM, FOP_SIGNED};
            default: {b.op_mode, b.func_op} = {OPM_REM, FOP_UNSIGNED};
          endcase
`else
          bad = 1'b1;
`endif
        end else begin
          bad = !((f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
          {b.op_mode, b.func_op} = alu_sel(f3, f7[5]);
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        b.op_mode = OPM_NONE;
      end
      default: bad = 1'b1;
    endcase

    // Illegal bundles carry no control or register fields, only the flag and raw funct3.
    if (bad) begin
      b         = '0;
      b.illegal = 1'b1;
    end
    b.funct3 = f3;
    if (b.rd == 5'd0) begin
      b.reg_write = 1'b0;
    end
    o_bundle = b;
  end

endmodule

// File: rtl/dec_stage.sv
// Registered decode stage: instruction FIFO, dec_core on the FIFO head, valid/ready output register.
// Build option DEC_RV32M_EN (consumed by dec_core) enables RV32M decode.
module dec_stage
  import dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_inst_data,
  input  logic [PC_W-1:0]          i_pc,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [PC_W-1:0]          o_pc,
  output logic [4:0]               o_rd,
  output logic [4:0]               o_rs1,
  output logic [4:0]               o_rs2,
  output logic [31:0]              o_imm,
  output logic [2:0]               o_funct3,
  output logic [2:0]               o_op_mode,
  output logic [2:0]               o_func_op,
  output logic                     o_alusrc,
  output logic                     o_mem_to_reg,
  output logic                     o_reg_write,
  output logic                     o_mem_read,
  output logic                     o_mem_write,
  output logic                     o_branch,
  output logic                     o_jump,
  output logic                     o_jalr,
  output logic                     o_pc_rel,
  output logic                     o_illegal,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  dec_bundle_t      out_bundle_q, out_bundle_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  dec_bundle_t      head_bundle;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;

  dec_core u_core (
    .i_inst   (inst_mem_q[rd_ptr_q]),
    .o_bundle (head_bundle)
  );

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign o_ready = !full && !i_rst;
  assign push    = i_valid && o_ready && !i_flush;
  assign load    = !empty && (!out_valid_q || i_ready) && !i_flush;

  always_comb begin
    inst_mem_d   = inst_mem_q;
    pc_mem_d     = pc_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_bundle_d = out_bundle_q;
    out_pc_d     = out_pc_q;
    if (i_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = i_inst_data;
        pc_mem_d[wr_ptr_q]   = i_pc;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        out_valid_d  = 1'b1;
        out_bundle_d = head_bundle;
        out_pc_d     = pc_mem_q[rd_ptr_q];
      end else if (out_valid_q && i_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(load);
    end
  end

  // FIFO storage is not reset; occupancy and pointers alone define its contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      out_pc_q     <= '0;
    end else begin
      inst_mem_q   <= inst_mem_d;
      pc_mem_q     <= pc_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_bundle_q <= out_bundle_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign o_valid      = out_valid_q;
  assign o_pc         = out_pc_q;
  assign o_rd         = out_bundle_q.rd;
  assign o_rs1        = out_bundle_q.rs1;
  assign o_rs2        = out_bundle_q.rs2;
  assign o_imm        = out_bundle_q.imm;
  assign o_funct3     = out_bundle_q.funct3;
  assign o_op_mode    = out_bundle_q.op_mode;
  assign o_func_op    = out_bundle_q.func_op;
  assign o_alusrc     = out_bundle_q.alusrc;
  assign o_mem_to_reg = out_bundle_q.mem_to_reg;
  assign o_reg_write  = out_bundle_q.reg_write;
  assign o_mem_read   = out_bundle_q.mem_read;
  assign o_mem_write  = out_bundle_q.mem_write;
  assign o_branch     = out_bundle_q.branch;
  assign o_jump       = out_bundle_q.jump;
  assign o_jalr       = out_bundle_q.jalr;
  assign o_pc_rel     = out_bundle_q.pc_rel;
  assign o_illegal    = out_bundle_q.illegal;
  assign o_count      = count_q;

endmodule
